// File: rtl/ctrl_pkg.sv
// Shared definitions for the decode/execute control-word stage: field layout,
// default width, NOP word and FSM state encoding.
package ctrl_pkg;

   localparam int CW_DEFAULT = 13;

   // Field layout, MSB first: am | rf_en | alu_op | load | branch_link | s_bit | rw | size | datamem_en
   localparam int AM_OFF     = 11;  localparam int AM_W     = 2;
   localparam int RF_EN_OFF  = 10;  localparam int RF_EN_W  = 1;
   localparam int ALU_OP_OFF = 6;   localparam int ALU_OP_W = 4;
   localparam int LOAD_OFF   = 5;   localparam int LOAD_W   = 1;
   localparam int BL_OFF     = 4;   localparam int BL_W     = 1;
   localparam int S_BIT_OFF  = 3;   localparam int S_BIT_W  = 1;
   localparam int RW_OFF     = 2;   localparam int RW_W     = 1;
   localparam int SIZE_OFF   = 1;   localparam int SIZE_W   = 1;
   localparam int DMEM_OFF   = 0;   localparam int DMEM_W   = 1;

   localparam logic [CW_DEFAULT-1:0] CTRL_NOP = '0;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      BUBBLE = 1'b1
   } state_e;

endpackage

// File: rtl/ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
module ctrl_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/ctrl_bubble_stage.sv
// Registered decode->execute control stage with load-use bubble insertion,
// flush squash and stall hold. CTRL_BUBBLE_STATS_EN adds bubble_count_out.
module ctrl_bubble_stage
   import ctrl_pkg::*;
#(
   parameter int            CW            = CW_DEFAULT,
   parameter int            BUBBLE_CYCLES = 1,
   parameter logic [CW-1:0] NOP_WORD      = {CW{1'b0}}
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [CW-1:0] ctrl_in,
   input  logic          hazard_in,
   input  logic          flush_in,
   input  logic          stall_in,
   output logic [CW-1:0] ctrl_out,
   output logic          valid_out,
   output logic          freeze_out,
   output logic          bubble_active_out
`ifdef CTRL_BUBBLE_STATS_EN
   ,
   output logic [15:0]   bubble_count_out
`endif
);

   generate
      if (BUBBLE_CYCLES < 1 || BUBBLE_CYCLES > 15) begin : g_bad_bubble_cycles
         $error("ctrl_bubble_stage: BUBBLE_CYCLES must be in 1..15");
      end
   endgenerate

   localparam logic [3:0] CNT_LOAD = 4'(BUBBLE_CYCLES - 1);
   localparam bit         MULTI    = (BUBBLE_CYCLES > 1);

   state_e        state_d, state_q;
   logic [3:0]    cnt_d, cnt_q;
   logic [CW-1:0] ctrl_d, ctrl_q;
   logic          valid_d, valid_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ctrl_d  = ctrl_q;
      valid_d = valid_q;
      if (flush_in) begin
         state_d = RUN;
         cnt_d   = '0;
         ctrl_d  = NOP_WORD;
         valid_d = 1'b0;
      end else if (!stall_in) begin
         case (state_q)
            RUN: begin
               if (hazard_in) begin
                  ctrl_d  = NOP_WORD;
                  valid_d = 1'b0;
                  if (MULTI) begin
                     cnt_d   = CNT_LOAD;
                     state_d = BUBBLE;
                  end
               end else begin
                  ctrl_d  = ctrl_in;
                  valid_d = 1'b1;
               end
            end
            BUBBLE: begin
               ctrl_d  = NOP_WORD;
               valid_d = 1'b0;
               cnt_d   = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
         ctrl_q  <= NOP_WORD;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctrl_q  <= ctrl_d;
         valid_q <= valid_d;
      end
   end

   // Stall freezes upstream even when a flush is present; bubble terms do not.
   assign freeze_out = stall_in |
                       (~flush_in & ((state_q == BUBBLE) | ((state_q == RUN) & hazard_in)));

   assign ctrl_out          = ctrl_q;
   assign valid_out         = valid_q;
   assign bubble_active_out = (state_q == BUBBLE);

`ifdef CTRL_BUBBLE_STATS_EN
   logic bubble_load;
   assign bubble_load = ~flush_in & ~stall_in &
                        ((state_q == BUBBLE) | ((state_q == RUN) & hazard_in));

   ctrl_sat_counter #(.W(16)) u_stats (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (bubble_load),
      .count_o (bubble_count_out)
   );
`else
`endif

endmodule

// File: doc/ctrl_bubble_stage.md
# ctrl_bubble_stage

Registered control-word stage between decode and execute. Passes the control unit's control word downstream. On a load-use hazard it inserts a programmable run of NOP bubbles and freezes upstream fetch/decode. It also squashes on branch flush and holds on an external stall. It generalises the combinational control-zeroing mux into a parametrised, stateful hazard stage.

## Interface
Parameters:
- CW, 13, control word width (am 2, rf_en 1, alu_op 4, load 1, branch_link 1, s_bit 1, rw 1, size 1, datamem_en 1)
- BUBBLE_CYCLES, 1, NOP cycles inserted per hazard; legal range 1..15
- NOP_WORD, {CW{1'b0}}, control word driven during a bubble or flush

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, synchronous and active-low
- ctrl_in  in  CW  control word from the control unit
- hazard_in  in  1  load-use hazard detected this cycle
- flush_in  in  1  branch taken; squash the instruction in decode
- stall_in  in  1  external hold, e.g. a memory wait
- ctrl_out  out  CW  registered control word to execute
- valid_out  out  1  ctrl_out carries a real instruction
- freeze_out  out  1  combinational; deasserts PC and IF/ID write enables
- bubble_active_out  out  1  FSM is in BUBBLE

## Operation
- FSM states: RUN, BUBBLE. A 4-bit counter cnt tracks the bubbles still to insert.
- Per-edge priority: reset > flush_in > stall_in > hazard/bubble > pass.
- Reset: ctrl_out=NOP_WORD, valid_out=0, state=RUN, cnt=0, bubble_active_out=0.
- flush_in=1 (any state): ctrl_out<=NOP_WORD, valid_out<=0, state<=RUN, cnt<=0. Any pending bubbles are discarded.
- stall_in=1 (no flush): ctrl_out, valid_out, state and cnt hold their values.
- RUN, hazard_in=1:
  - ctrl_out<=NOP_WORD, valid_out<=0.
  - If BUBBLE_CYCLES>1: cnt<=BUBBLE_CYCLES-1, state<=BUBBLE.
  - Otherwise stay in RUN.
- RUN, hazard_in=0: ctrl_out<=ctrl_in, valid_out<=1.
- BUBBLE: ctrl_out<=NOP_WORD, valid_out<=0, cnt<=cnt-1. When cnt==1, state<=RUN. hazard_in is ignored in BUBBLE and re-evaluated in RUN.
- freeze_out = stall_in | (state==BUBBLE) | (state==RUN & hazard_in). Each term is masked by ~flush_in except stall_in.
- Total NOPs per hazard is exactly BUBBLE_CYCLES. Total upstream freeze cycles is exactly BUBBLE_CYCLES.

## Timing
- Latency from ctrl_in to ctrl_out: 1 cycle.
- freeze_out and bubble_active_out: bubble_active_out is registered from state; freeze_out is combinational from the current inputs and state.
- A hazard asserted at edge N produces a NOP at ctrl_out from N+1 through N+BUBBLE_CYCLES. The held instruction appears at N+BUBBLE_CYCLES+1.
- Stall during BUBBLE extends the bubble window by the stall length. The cnt value is preserved across the stall.
- Simultaneous hazard_in and flush_in: flush wins; no bubble is started.
- Simultaneous hazard_in and stall_in: stall wins; the hazard is re-sampled after the stall.
- Reset asserted mid-bubble: next edge returns to the reset values.

## Configuration
- CTRL_BUBBLE_STATS_EN defined:
  - Adds output bubble_count_out [15:0].
  - It increments on every edge where a hazard-caused NOP is loaded (RUN-hazard or BUBBLE, not stalled, not flushed).
  - It saturates at 16'hFFFF and resets to 0.
- Undefined: the port and its counter are absent. Behaviour is otherwise identical.

## Structure
- Shared package ctrl_pkg holds:
  - control word field offsets and widths
  - CW_DEFAULT
  - the NOP control word constant
  - the state enum (RUN, BUBBLE)
- The parameter range check on BUBBLE_CYCLES is done at elaboration.
- One sub-module, ctrl_sat_counter (parametrised width, saturating increment, synchronous active-low clear), is instantiated only under CTRL_BUBBLE_STATS_EN.

## Test plan
- Reset with rst_n=0 for 2 cycles, ctrl_in=13'h1FFF -> ctrl_out=0, valid_out=0, freeze_out=0, bubble_active_out=0.
- BUBBLE_CYCLES=1, ctrl_in=13'h0A5, hazard_in pulsed 1 cycle -> one NOP cycle with freeze_out=1 during the hazard cycle; 13'h0A5 appears on the following cycle with valid_out=1.
- BUBBLE_CYCLES=3, hazard pulse -> 3 consecutive NOPs; bubble_active_out high for 2 cycles; freeze_out high for 3 cycles.
- BUBBLE_CYCLES=3, stall_in=1 for 2 cycles in the middle of the bubble -> 5 NOP cycles total; cnt resumes correctly.
- hazard_in=1 and flush_in=1 on the same edge -> a single NOP, state stays RUN, freeze_out=0.
- With CTRL_BUBBLE_STATS_EN and bubble_count_out preloaded near saturation: 65540 hazard bubbles -> bubble_count_out=16'hFFFF; a flush does not increment it.
